// File: rtl/csa_pipe.sv
// rtl/csa_pipe.sv - pipelined carry-skip adder/subtractor, one register rank per skip group
// Rank 0 captures the beat; group k is evaluated between rank k and rank k+1.
module csa_pipe #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int BLK_SAFE = (BLK < 1) ? 1 : BLK;
  localparam int NBLK     = WIDTH / BLK_SAFE;

  generate
    if (BLK < 1 || WIDTH < BLK_SAFE || (WIDTH % BLK_SAFE) != 0) begin : g_bad_params
      $error("csa_pipe: WIDTH must be a non-zero multiple of BLK and BLK must be >= 1");
    end
  endgenerate

  logic [NBLK:0]      r_vld;
  logic [WIDTH-1:0]   r_a [NBLK];
  logic [WIDTH-1:0]   r_b [NBLK];
  logic [WIDTH-1:0]   r_s [NBLK+1];
  logic [NBLK:0]      r_c;
  logic               r_ovf;

  logic               w_adv;
  logic [WIDTH-1:0]   w_s_nxt [NBLK];
  logic [NBLK-1:0]    w_c_nxt;
  logic               w_cmsb;
  logic               w_cy;
  logic               w_p;
  logic               w_x;

  // The whole pipe moves together; a held result freezes every rank.
  assign w_adv    = ~r_vld[NBLK] | out_ready;
  assign in_ready = w_adv;

  always_comb begin
    w_cmsb  = 1'b0;
    w_c_nxt = '0;
    w_cy    = 1'b0;
    w_p     = 1'b0;
    w_x     = 1'b0;
    for (int k = 0; k < NBLK; k++) begin
      w_s_nxt[k] = r_s[k];
      w_cy       = r_c[k];
      w_p        = 1'b1;
      for (int i = 0; i < BLK; i++) begin
        w_x = r_a[k][k*BLK+i] ^ r_b[k][k*BLK+i];
        w_s_nxt[k][k*BLK+i] = w_x ^ w_cy;
        if (k == NBLK-1 && i == BLK-1) begin
          w_cmsb = w_cy;
        end
        w_cy = (r_a[k][k*BLK+i] & r_b[k][k*BLK+i]) | (w_x & w_cy);
        w_p  = w_p & w_x;
      end
      // XOR propagate: a fully propagating group passes its carry-in straight through.
      w_c_nxt[k] = w_p ? r_c[k] : w_cy;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_c   <= '0;
      r_ovf <= 1'b0;
      for (int k = 0; k < NBLK; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
      end
      for (int k = 0; k <= NBLK; k++) begin
        r_s[k] <= '0;
      end
    end else if (w_adv) begin
      r_vld       <= {r_vld[NBLK-1:0], in_valid};
      r_c[NBLK:1] <= w_c_nxt;
      if (in_valid) begin
        r_a[0] <= a;
        r_b[0] <= sub ? ~b : b;
        r_c[0] <= cin ^ sub;
      end
      for (int k = 1; k < NBLK; k++) begin
        r_a[k] <= r_a[k-1];
        r_b[k] <= r_b[k-1];
      end
      r_s[0] <= '0;
      for (int k = 1; k <= NBLK; k++) begin
        r_s[k] <= w_s_nxt[k-1];
      end
      r_ovf <= w_cmsb ^ w_c_nxt[NBLK-1];
    end
  end

  assign out_valid = r_vld[NBLK];
  assign sum       = r_s[NBLK];
  assign cout      = r_c[NBLK];
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_csa_pipe.sv
// tb/tb_csa_pipe.sv - directed and randomised checks of csa_pipe (WIDTH=16, BLK=4)
module tb_csa_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int          n_tests = 0;
  int          n_fail = 0;
  int          n_extra = 0;
  int          n_timeout = 0;
  int          cyc = 0;
  logic        rnd_mode = 1'b0;
  logic [17:0] sb[$];

  csa_pipe #(.WIDTH(16), .BLK(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] pk(input logic [15:0] s, input logic c, input logic o);
    return {c, o, s};
  endfunction

  function automatic logic [17:0] model(input logic [15:0] fa, input logic [15:0] fb,
                                        input logic fc, input logic fs);
    logic [16:0] r;
    int          sr;
    if (fs) begin
      r  = {1'b0, fa} + {1'b0, ~fb} + 17'(!fc);
      sr = int'($signed(fa)) - int'($signed(fb)) - int'(fc);
    end else begin
      r  = {1'b0, fa} + {1'b0, fb} + 17'(fc);
      sr = int'($signed(fa)) + int'($signed(fb)) + int'(fc);
    end
    return {r[16], (sr > 32767 || sr < -32768), r[15:0]};
  endfunction

  // Called and returns one time unit after a rising edge.
  task automatic send(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                      input logic is, input logic [17:0] exp);
    int   n;
    logic ok;
    a = ia; b = ib; cin = ic; sub = is; in_valid = 1'b1;
    n = 0; ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      n++;
    end
    if (ok) sb.push_back(exp);
    else    n_timeout++;
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(tag, sb.size(), 0);
  endtask

  task automatic latency(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, n, 4);
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) n_extra++;
      else chk("beat", {cout, ovf, sum}, sb.pop_front());
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int          cyc0;
    int          nv;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic        rs;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(16'h00FF, 16'h0001, 1'b0, 1'b0, pk(16'h0100, 1'b0, 1'b0));
    latency("latency_first");
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, pk(16'h0000, 1'b1, 1'b0));
    send(16'h5555, 16'hAAAA, 1'b1, 1'b0, pk(16'h0000, 1'b1, 1'b0));
    send(16'h0005, 16'h0007, 1'b0, 1'b1, pk(16'hFFFE, 1'b0, 1'b0));
    send(16'h8000, 16'h0001, 1'b0, 1'b1, pk(16'h7FFF, 1'b1, 1'b1));
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, pk(16'h8000, 1'b0, 1'b1));
    send(16'h0007, 16'h0005, 1'b1, 1'b1, pk(16'h0001, 1'b1, 1'b0));
    send(16'h0000, 16'h0000, 1'b0, 1'b1, pk(16'h0000, 1'b1, 1'b0));
    drain("drain_directed");

    cyc0 = cyc;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(16'(i), 16'(32'h1000 * i), 1'b0, 1'b0, pk(16'(32'h1000 * i + i), 1'b0, 1'b0));
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready, 0);
          chk("stall_out_valid", out_valid, 1);
          chk("stall_sum", sum, 16'h0000);
          @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
      end
    join
    while (sb.size() != 0 && (cyc - cyc0) < 100) begin
      @(posedge clk);
      #1;
    end
    chk("stall_total_cycles", cyc - cyc0, 16);

    out_ready = 1'b0;
    send(16'h1234, 16'h1111, 1'b0, 1'b0, pk(16'h2345, 1'b0, 1'b0));
    send(16'h0001, 16'h0001, 1'b0, 1'b0, pk(16'h0002, 1'b0, 1'b0));
    send(16'h0002, 16'h0002, 1'b0, 1'b0, pk(16'h0004, 1'b0, 1'b0));
    send(16'h0003, 16'h0003, 1'b0, 1'b0, pk(16'h0006, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    chk("held_out_valid", out_valid, 1);
    chk("held_sum", sum, 16'h2345);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_sum", sum, 0);
    chk("async_rst_cout", cout, 0);
    chk("async_rst_ovf", ovf, 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    nv = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid) nv++;
    end
    chk("no_stale_beats", nv, 0);
    send(16'h0F0F, 16'h00F1, 1'b0, 1'b0, pk(16'h1000, 1'b0, 1'b0));
    latency("latency_after_reset");
    drain("drain_reset");

    rnd_mode = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      send(ra, rb, rc, rs, model(ra, rb, rc, rs));
    end
    rnd_mode = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain("drain_random");

    chk("extra_beats", n_extra, 0);
    chk("send_timeouts", n_timeout, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
